// File: rtl/irq_ctrl.sv
// irq_ctrl: parametrised interrupt controller between the board buttons and the
// CPU execute stage. It synchronises the raw sources and captures them as edges
// or levels. A mask register gates eligibility, and sticky flags record lost
// edges. An IDLE/SERVICE state machine allows one handler at a time, with no
// nesting.
module irq_ctrl #(
   parameter int                NUM_IRQ     = 4,
   parameter int                ADDR_W      = 16,
   parameter logic [ADDR_W-1:0] VEC_BASE    = 16'h0f80,
   parameter logic [ADDR_W-1:0] VEC_STRIDE  = 16'h0020,
   parameter bit                EDGE_MODE   = 1'b1,
   parameter int                SYNC_STAGES = 2,
   parameter int                ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_wr_en,
   input  logic [NUM_IRQ-1:0] mask_wr_data,
   input  logic               ovf_clr,
   input  logic               int_ack,
   input  logic               ret,
   output logic               int_req,
   output logic [ADDR_W-1:0]  int_vector,
   output logic [ID_W-1:0]    int_id,
   output logic               in_service,
   output logic [ID_W-1:0]    active_id,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] mask,
   output logic [NUM_IRQ-1:0] overflow
);

   typedef enum logic {IDLE, SERVICE} state_t;

   state_t             state;
   logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IRQ-1:0] s;
   logic [NUM_IRQ-1:0] s_prev;
   logic [NUM_IRQ-1:0] edge_det;
   logic [NUM_IRQ-1:0] eligible;
   logic [NUM_IRQ-1:0] clr;
   logic               ack_fire;
   logic [ADDR_W-1:0]  slot;

   assign s        = sync_q[SYNC_STAGES-1];
   assign edge_det = s & ~s_prev;

   // Synchroniser chain for the asynchronous buttons, plus one extra flop of edge history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         s_prev <= '0;
      end else begin
         sync_q[0] <= irq_in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         s_prev <= s;
      end
   end

   // An ack only counts while a request is actually presented, which also limits it to IDLE
   assign ack_fire = int_ack & int_req;

   // One-hot clear of the channel that is being acknowledged this cycle
   always_comb begin
      clr = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         clr[i] = ack_fire && (int_id == ID_W'(i));
      end
   end

   generate
      if (EDGE_MODE) begin : g_edge
         logic [NUM_IRQ-1:0] pend_q;
         logic [NUM_IRQ-1:0] ovf_q;
         logic [NUM_IRQ-1:0] ovf_set;

         // Lost edge: a new edge hits a bit that is already pending and is not being retired
         assign ovf_set = edge_det & pend_q & ~clr;

         // Pending and overflow capture. A set beats a coincident clear, so no edge is dropped
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pend_q <= '0;
               ovf_q  <= '0;
            end else begin
               pend_q <= (pend_q & ~clr) | edge_det;
               ovf_q  <= (ovf_clr ? '0 : ovf_q) | ovf_set;
            end
         end

         assign pending  = pend_q;
         assign overflow = ovf_q;
      end else begin : g_level
         logic lvl_unused;

         // Level capture tracks the synchronised input directly; acks and ovf_clr have no effect here
         assign lvl_unused = ^{edge_det, clr, ovf_clr};
         assign pending    = s;
         assign overflow   = '0;
      end
   endgenerate

   // Mask register; a write in the same cycle as an ack only takes effect afterwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mask <= '0;
      else if (mask_wr_en) mask <= mask_wr_data;
   end

   assign eligible = pending & ~mask;

   // Highest eligible index wins; 0 when nothing is eligible
   always_comb begin
      int_id = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (eligible[i]) int_id = ID_W'(i);
      end
   end

   // The highest channel maps to VEC_BASE, and lower channels step upward by VEC_STRIDE
   assign slot       = ADDR_W'(NUM_IRQ - 1) - ADDR_W'(int_id);
   assign int_vector = VEC_BASE + slot * VEC_STRIDE;

   assign int_req    = (|eligible) && (state == IDLE);
   assign in_service = (state == SERVICE);

   // Service FSM: enter on an accepted ack, leave on ret; no nesting while a handler runs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         active_id <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ack_fire) begin
                  state     <= SERVICE;
                  active_id <= int_id;
               end
            end
            SERVICE: begin
               if (ret) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: a default edge-mode instance and an 8-channel level-mode
// instance. Expected values are queued when stimulus is applied and compared
// once the DUT has had time to respond.
module tb_irq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [3:0]  irq_in, mask_wr_data;
   logic        mask_wr_en, ovf_clr, int_ack, ret;
   logic        int_req, in_service;
   logic [15:0] int_vector;
   logic [1:0]  int_id, active_id;
   logic [3:0]  pending, mask, overflow;

   logic [7:0]  l_irq, l_mask_wr_data;
   logic        l_mask_wr_en, l_ovf_clr, l_ack, l_ret;
   logic        l_req, l_insv;
   logic [15:0] l_vec;
   logic [2:0]  l_id, l_aid;
   logic [7:0]  l_pend, l_mask, l_ovf;

   irq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask_wr_en(mask_wr_en),
      .mask_wr_data(mask_wr_data), .ovf_clr(ovf_clr), .int_ack(int_ack), .ret(ret),
      .int_req(int_req), .int_vector(int_vector), .int_id(int_id),
      .in_service(in_service), .active_id(active_id), .pending(pending),
      .mask(mask), .overflow(overflow)
   );

   irq_ctrl #(.NUM_IRQ(8), .EDGE_MODE(1'b0)) dut_lvl (
      .clk(clk), .rst_n(rst_n), .irq_in(l_irq), .mask_wr_en(l_mask_wr_en),
      .mask_wr_data(l_mask_wr_data), .ovf_clr(l_ovf_clr), .int_ack(l_ack), .ret(l_ret),
      .int_req(l_req), .int_vector(l_vec), .int_id(l_id),
      .in_service(l_insv), .active_id(l_aid), .pending(l_pend),
      .mask(l_mask), .overflow(l_ovf)
   );

   typedef enum int {O_REQ, O_ID, O_VEC, O_INSV, O_AID, O_PEND, O_MASK, O_OVF,
                     L_REQ, L_ID, L_VEC, L_INSV, L_AID, L_PEND, L_OVF} sel_t;
   typedef struct {
      sel_t        sel;
      logic [31:0] val;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [31:0] obs(sel_t s);
      case (s)
         O_REQ:   return 32'(int_req);
         O_ID:    return 32'(int_id);
         O_VEC:   return 32'(int_vector);
         O_INSV:  return 32'(in_service);
         O_AID:   return 32'(active_id);
         O_PEND:  return 32'(pending);
         O_MASK:  return 32'(mask);
         O_OVF:   return 32'(overflow);
         L_REQ:   return 32'(l_req);
         L_ID:    return 32'(l_id);
         L_VEC:   return 32'(l_vec);
         L_INSV:  return 32'(l_insv);
         L_AID:   return 32'(l_aid);
         L_PEND:  return 32'(l_pend);
         default: return 32'(l_ovf);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input sel_t s, input logic [31:0] v, input string tag);
      exp_t e;
      e.sel = s;
      e.val = v;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, obs(e.sel), e.val);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_ack();
      int_ack = 1'b1;
      cyc(1);
      int_ack = 1'b0;
   endtask

   task automatic do_ret();
      ret = 1'b1;
      cyc(1);
      ret = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      irq_in = '0; mask_wr_data = '0; mask_wr_en = 1'b0; ovf_clr = 1'b0;
      int_ack = 1'b0; ret = 1'b0;
      l_irq = '0; l_mask_wr_data = '0; l_mask_wr_en = 1'b0; l_ovf_clr = 1'b0;
      l_ack = 1'b0; l_ret = 1'b0;
      cyc(2);
      expect_out(O_REQ, 0, "rst_req");
      expect_out(O_ID, 0, "rst_id");
      expect_out(O_VEC, 16'h0fe0, "rst_vec");
      expect_out(O_INSV, 0, "rst_insv");
      expect_out(O_PEND, 0, "rst_pend");
      expect_out(O_OVF, 0, "rst_ovf");
      expect_out(L_VEC, 16'h0f80 + 7 * 16'h20, "rst_lvl_vec");
      sb_check();
      rst_n = 1'b1;
      cyc(1);

      // Single edge on channel 2: latency, request, ack, return
      irq_in[2] = 1'b1;
      expect_out(O_PEND, 0, "t1_pend_before_latency");
      cyc(2);
      sb_check();
      expect_out(O_PEND, 4'b0100, "t1_pend");
      expect_out(O_REQ, 1, "t1_req");
      expect_out(O_ID, 2, "t1_id");
      expect_out(O_VEC, 16'h0fa0, "t1_vec");
      cyc(1);
      sb_check();
      irq_in[2] = 1'b0;
      expect_out(O_INSV, 1, "t1_insv");
      expect_out(O_AID, 2, "t1_aid");
      expect_out(O_PEND, 0, "t1_pend_clr");
      expect_out(O_REQ, 0, "t1_req_svc");
      do_ack();
      sb_check();
      expect_out(O_INSV, 0, "t1_insv_ret");
      expect_out(O_REQ, 0, "t1_req_ret");
      do_ret();
      sb_check();

      // Priority: channels 0 and 3 together, then back-to-back service of channel 0
      irq_in = 4'b1001;
      expect_out(O_ID, 3, "t2_id");
      expect_out(O_VEC, 16'h0f80, "t2_vec");
      cyc(3);
      sb_check();
      irq_in = '0;
      expect_out(O_AID, 3, "t2_aid");
      expect_out(O_PEND, 4'b0001, "t2_pend_after_ack");
      do_ack();
      sb_check();
      expect_out(O_REQ, 1, "t2_req_b2b");
      expect_out(O_ID, 0, "t2_id_b2b");
      expect_out(O_VEC, 16'h0fe0, "t2_vec_b2b");
      do_ret();
      sb_check();
      do_ack();
      do_ret();

      // Mask: a masked channel still captures pending and fires once unmasked
      mask_wr_en = 1'b1; mask_wr_data = 4'b1000;
      expect_out(O_MASK, 4'b1000, "t3_mask");
      cyc(1);
      mask_wr_en = 1'b0;
      sb_check();
      irq_in[3] = 1'b1;
      expect_out(O_PEND, 4'b1000, "t3_pend_masked");
      expect_out(O_REQ, 0, "t3_req_masked");
      cyc(3);
      sb_check();
      irq_in[3] = 1'b0;
      mask_wr_en = 1'b1; mask_wr_data = 4'b0000;
      expect_out(O_REQ, 1, "t3_req_unmasked");
      expect_out(O_VEC, 16'h0f80, "t3_vec_unmasked");
      cyc(1);
      mask_wr_en = 1'b0;
      sb_check();
      do_ack();
      do_ret();

      // Overflow: two edges on channel 1 without an ack, then clear
      irq_in[1] = 1'b1;
      expect_out(O_OVF, 0, "t4_ovf_first");
      cyc(3);
      sb_check();
      irq_in[1] = 1'b0;
      cyc(3);
      irq_in[1] = 1'b1;
      expect_out(O_OVF, 4'b0010, "t4_ovf_set");
      expect_out(O_PEND, 4'b0010, "t4_pend");
      cyc(3);
      sb_check();
      irq_in[1] = 1'b0;
      ovf_clr = 1'b1;
      expect_out(O_OVF, 0, "t4_ovf_clr");
      cyc(1);
      ovf_clr = 1'b0;
      sb_check();
      cyc(3);
      // Edge arrives on the same clock that acks channel 1
      irq_in[1] = 1'b1;
      cyc(2);
      expect_out(O_PEND, 4'b0010, "t4_pend_kept");
      expect_out(O_OVF, 0, "t4_ovf_no_set");
      expect_out(O_AID, 1, "t4_aid");
      do_ack();
      sb_check();
      irq_in[1] = 1'b0;
      expect_out(O_REQ, 1, "t4_req_after_ret");
      expect_out(O_ID, 1, "t4_id_after_ret");
      do_ret();
      sb_check();
      do_ack();
      do_ret();

      // No nesting: edge during service only accumulates; ret+ack together returns to IDLE
      irq_in[0] = 1'b1;
      cyc(3);
      irq_in[0] = 1'b0;
      do_ack();
      irq_in[3] = 1'b1;
      expect_out(O_PEND, 4'b1000, "t5_pend_svc");
      expect_out(O_REQ, 0, "t5_req_svc");
      expect_out(O_INSV, 1, "t5_insv");
      cyc(3);
      sb_check();
      irq_in[3] = 1'b0;
      ret = 1'b1; int_ack = 1'b1;
      expect_out(O_INSV, 0, "t5_insv_ret_ack");
      expect_out(O_PEND, 4'b1000, "t5_pend_ret_ack");
      expect_out(O_REQ, 1, "t5_req_ret_ack");
      expect_out(O_ID, 3, "t5_id_ret_ack");
      cyc(1);
      ret = 1'b0; int_ack = 1'b0;
      sb_check();
      do_ack();
      do_ret();

      // Asynchronous reset while in SERVICE with pending 4'b0110
      mask_wr_en = 1'b1; mask_wr_data = 4'b0001;
      cyc(1);
      mask_wr_en = 1'b0;
      irq_in = 4'b0110;
      cyc(3);
      irq_in = '0;
      do_ack();
      cyc(2);
      irq_in[2] = 1'b1;
      expect_out(O_PEND, 4'b0110, "t6_pend_pre");
      expect_out(O_INSV, 1, "t6_insv_pre");
      cyc(3);
      sb_check();
      irq_in = '0;
      #2;
      rst_n = 1'b0;
      #1;
      expect_out(O_REQ, 0, "t6_req_rst");
      expect_out(O_ID, 0, "t6_id_rst");
      expect_out(O_VEC, 16'h0fe0, "t6_vec_rst");
      expect_out(O_INSV, 0, "t6_insv_rst");
      expect_out(O_AID, 0, "t6_aid_rst");
      expect_out(O_PEND, 0, "t6_pend_rst");
      expect_out(O_MASK, 0, "t6_mask_rst");
      expect_out(O_OVF, 0, "t6_ovf_rst");
      sb_check();
      #1;
      rst_n = 1'b1;
      cyc(1);

      // Level mode, 8 channels: pending follows the held input even after an ack
      l_irq[5] = 1'b1;
      expect_out(L_PEND, 0, "lvl_pend_before_latency");
      cyc(1);
      sb_check();
      expect_out(L_PEND, 8'h20, "lvl_pend");
      expect_out(L_REQ, 1, "lvl_req");
      expect_out(L_ID, 5, "lvl_id");
      expect_out(L_VEC, 16'h0fc0, "lvl_vec");
      cyc(1);
      sb_check();
      l_ack = 1'b1;
      expect_out(L_INSV, 1, "lvl_insv");
      expect_out(L_AID, 5, "lvl_aid");
      expect_out(L_PEND, 8'h20, "lvl_pend_after_ack");
      expect_out(L_OVF, 0, "lvl_ovf");
      cyc(1);
      l_ack = 1'b0;
      sb_check();
      l_irq[5] = 1'b0;
      l_ret = 1'b1;
      cyc(1);
      l_ret = 1'b0;
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller that sits between the board button inputs and the CPU execute stage.
- Generalises the fixed 4-button, hard-priority interrupt redirect into NUM_IRQ channels.
- Adds synchronisers, edge or level capture, a mask register, sticky overflow flags and an IDLE/SERVICE state machine.
- The execute stage consumes int_req/int_vector, pulses int_ack when it redirects the PC, and pulses ret on a qualified (unflushed) RET.

Parameters:
NUM_IRQ, 4, number of interrupt channels (1..16)
ADDR_W, 16, width of the PC/vector
VEC_BASE, 16'h0f80, vector of the highest-priority channel
VEC_STRIDE, 16'h0020, address spacing between consecutive vectors
EDGE_MODE, 1, 1 = rising edge latched into pending; 0 = pending follows the synchronised level
SYNC_STAGES, 2, synchroniser depth on irq_in (at least 1)
ID_W, max(1,$clog2(NUM_IRQ)), width of the channel index

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
irq_in  in  NUM_IRQ  raw active-high interrupt sources (buttons), asynchronous to clk
mask_wr_en  in  1  write strobe for the mask register
mask_wr_data  in  NUM_IRQ  new mask value; 1 = channel masked
ovf_clr  in  1  clears all overflow flags
int_ack  in  1  execute stage took the redirect this cycle
ret  in  1  qualified RET retired in execute
int_req  out  1  an interrupt is requesting a redirect
int_vector  out  ADDR_W  redirect target for int_id
int_id  out  ID_W  highest-priority eligible channel
in_service  out  1  handler active (SERVICE state)
active_id  out  ID_W  channel currently being serviced
pending  out  NUM_IRQ  pending register
mask  out  NUM_IRQ  mask register
overflow  out  NUM_IRQ  sticky lost-edge flags

Behaviour:
- Reset (asynchronous, rst_n low) clears all of the following:
  - synchroniser flops, edge-history flops, pending, mask, overflow, active_id;
  - FSM goes to IDLE;
  - resulting outputs: int_req=0, int_id=0, int_vector=VEC_BASE+(NUM_IRQ-1)*VEC_STRIDE, in_service=0.
  - Reset during SERVICE abandons the handler; no ret is required afterwards.
- Synchroniser: irq_in passes through SYNC_STAGES flops to give s. An edge is s & ~s_prev, where s_prev is one more flop.
  - Input-to-pending latency is SYNC_STAGES+1 cycles in edge mode and SYNC_STAGES cycles in level mode.
- EDGE_MODE=1:
  - pending[i] sets on edge[i].
  - pending[i] clears on the cycle int_ack is accepted with int_id==i.
  - A set and a clear of the same bit in the same cycle leave the bit set (the new edge is not lost).
  - An edge on a bit that is already 1 (and not being cleared that cycle) sets overflow[i].
- EDGE_MODE=0: pending = s each cycle; int_ack does not clear it; overflow stays 0.
- Mask register:
  - Written on mask_wr_en; visible from the next cycle.
  - Masking does not stop capture: a masked channel still latches pending and can fire once it is unmasked.
- ovf_clr clears all overflow bits. If it coincides with a new overflow event, the set wins.
- Priority and vector:
  - eligible = pending & ~mask.
  - int_id = highest set index of eligible; 0 if none.
  - int_vector = VEC_BASE + (NUM_IRQ-1-int_id)*VEC_STRIDE, computed modulo 2^ADDR_W.
  - With the defaults: ch3 -> 0x0f80, ch2 -> 0x0fa0, ch1 -> 0x0fc0, ch0 -> 0x0fe0.
- int_req = (|eligible) & (state==IDLE).
  - int_req, int_id and int_vector are decoded from registers only; there is no combinational path from any input.
  - int_id may change while int_req is high, e.g. when a higher-priority channel arrives. An ack always applies to the value presented in that same cycle.
- FSM:
  - IDLE: int_ack with int_req=1 -> SERVICE; active_id <= int_id. int_ack with int_req=0 is ignored. ret is ignored.
  - SERVICE: ret -> IDLE. int_ack is ignored. There is no nesting; new edges only accumulate in pending.
  - ret and int_ack in the same cycle while in SERVICE: ret wins, the state returns to IDLE, and pending is unchanged.
- After returning to IDLE, int_req can reassert on the very next cycle (back-to-back service).
- mask_wr_en in the same cycle as int_ack: the ack uses the old mask.

Test Plan:
- Defaults, edge mode. Pulse irq_in[2] for 3 cycles -> pending=4'b0100 after 3 cycles; int_req=1, int_id=2, int_vector=0x0fa0. Pulse int_ack -> in_service=1, active_id=2, pending=0, int_req=0. Pulse ret -> IDLE, int_req=0.
- Priority: raise ch0 and ch3 edges together -> int_id=3, vector 0x0f80. Ack, then ret -> next cycle int_req=1, int_id=0, vector 0x0fe0.
- Mask: write mask=4'b1000, then an edge on ch3 -> pending[3]=1, int_req=0. Write mask=0 -> int_req=1 the next cycle with vector 0x0f80.
- Overflow: two separate edges on ch1 with no ack in between -> overflow=4'b0010. Pulse ovf_clr -> overflow=0. Also check an edge coinciding with the ack of ch1: pending[1] remains 1 and overflow stays 0.
- No nesting: in SERVICE, an edge on ch3 gives pending[3]=1 but int_req=0. A coincident ret+int_ack -> IDLE, pending[3] is still 1, int_req=1 the next cycle.
- Reset mid-SERVICE with pending=4'b0110 -> all outputs go to their reset values immediately (asynchronously). Level mode (EDGE_MODE=0, NUM_IRQ=8): hold irq_in[5] high -> int_id=5, vector 0x0f80+2*0x20=0x0fc0. pending[5] stays set after the ack while irq_in[5] is high.
